gate_bist: RTL and testbench

Synthesizable exhaustive self-test engine for a single 2-input logic gate. It drives all four input combinations into an external gate, waits a programmable settle time, samples the gate output and compares it against the expected function for the selected operation. It reports mismatches, the first failing vector and a pass/fail verdict. It sits next to the gate under test and checks it in hardware.

---
 rtl/gate_bist.sv | 152 +++++++++++++++
 tb/tb_gate_bist.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// Exhaustive self-test engine for one 2-input gate: walks vectors 00..11, waits for the gate
// to settle, samples its output and reports mismatch count, first failing vector and a verdict.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [1:0]       first_err_vec
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ErrMax     = '1;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic [1:0]       op_q, op_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             fev_q, fev_d;
    logic [1:0]       fvec_q, fvec_d;

    logic expected;
    logic mismatch;
    logic settle_done;
    logic last_vec;

    always_comb begin
        unique case (op_q)
            2'b00:   expected = vec_q[1] & vec_q[0];
            2'b01:   expected = vec_q[1] | vec_q[0];
            2'b10:   expected = vec_q[1] ^ vec_q[0];
            default: expected = ~(vec_q[1] & vec_q[0]);
        endcase
    end

    assign mismatch    = (state_q == StSample) && (dut_out != expected);
    assign settle_done = (cnt_q == SettleLast);
    assign last_vec    = (vec_q == 2'b11);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (settle_done) state_d = StSample;
            StSample: state_d = last_vec ? StDone : StSettle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        op_d   = op_q;
        err_d  = err_q;
        pass_d = pass_q;
        fev_d  = fev_q;
        fvec_d = fvec_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = op;
                    err_d  = '0;
                    pass_d = 1'b0;
                    fev_d  = 1'b0;
                    fvec_d = 2'b00;
                    vec_d  = 2'b00;
                    cnt_d  = '0;
                end
            end
            StSettle: begin
                cnt_d = settle_done ? 8'd0 : cnt_q + 8'd1;
            end
            StSample: begin
                if (mismatch) begin
                    if (err_q != ErrMax) err_d = err_q + 1'b1;
                    if (!fev_q) begin
                        fev_d  = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                cnt_d = '0;
                if (last_vec) begin
                    // Verdict lands together with the DONE pulse; gate inputs park at 0.
                    vec_d  = 2'b00;
                    pass_d = !fev_q && !mismatch;
                end else begin
                    vec_d = vec_q + 2'b01;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            vec_q  <= 2'b00;
            op_q   <= 2'b00;
            err_q  <= '0;
            pass_q <= 1'b0;
            fev_q  <= 1'b0;
            fvec_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            op_q   <= op_d;
            err_q  <= err_d;
            pass_q <= pass_d;
            fev_q  <= fev_d;
            fvec_q <= fvec_d;
        end
    end

    // Outputs
    always_comb begin
        busy            = (state_q == StSettle) || (state_q == StSample);
        done            = (state_q == StDone);
        dut_a           = vec_q[1];
        dut_b           = vec_q[0];
        pass            = pass_q;
        err_count       = err_q;
        first_err_valid = fev_q;
        first_err_vec   = fvec_q;
    end

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: a truth-table gate model feeds dut_out; expected results come from
// counting disagreements between the gate table and the selected function.
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic [1:0] op0, op1;
    logic       a0, b0, a1, b1;
    logic       out0, out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic       fev0, fev1;
    logic [1:0] fvec0, fvec1;
    logic [3:0] tt0, tt1;

    assign out0 = tt0[{a0, b0}];
    assign out1 = tt1[{a1, b1}];

    gate_bist #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0), .dut_a(a0), .dut_b(b0),
        .dut_out(out0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_vec(fvec0)
    );

    gate_bist #(.SETTLE_CYCLES(1), .ERR_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .dut_a(a1), .dut_b(b1),
        .dut_out(out1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fev1), .first_err_vec(fvec1)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    always @(posedge clk) begin
        if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_f(input logic [1:0] o, input int v);
        logic a, b;
        a = ((v / 2) % 2) == 1;
        b = (v % 2) == 1;
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return !(a & b);
        endcase
    endfunction

    task automatic model(input logic [1:0] o, input logic [3:0] g, output int errs,
                         output int first);
        errs  = 0;
        first = -1;
        for (int v = 0; v < 4; v++) begin
            if (ref_f(o, v) != g[v]) begin
                if (first < 0) first = v;
                errs++;
            end
        end
    endtask

    // One full run on the SETTLE_CYCLES=2 instance; op is scrambled after acceptance.
    task automatic run0(input logic [1:0] o, input logic [3:0] g, input bit hold, input string nm);
        int errs, first, d0;
        model(o, g, errs, first);
        tt0    = g;
        op0    = o;
        start0 = 1'b1;
        d0     = done_cnt0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            if (!hold) start0 = 1'b0;
            op0 = 2'($urandom);
            if (c < 13) begin
                chk({nm, "_vec"}, {6'd0, a0, b0}, 8'((c - 1) / 3));
                chk({nm, "_busy"}, {7'd0, busy0}, 8'd1);
                chk({nm, "_done_lo"}, {7'd0, done0}, 8'd0);
            end else begin
                chk({nm, "_done"}, {7'd0, done0}, 8'd1);
                chk({nm, "_busy_end"}, {7'd0, busy0}, 8'd0);
                chk({nm, "_park"}, {6'd0, a0, b0}, 8'd0);
                chk({nm, "_pass"}, {7'd0, pass0}, {7'd0, errs == 0});
                chk({nm, "_errcnt"}, {5'd0, err0}, 8'(errs));
                chk({nm, "_fev"}, {7'd0, fev0}, {7'd0, errs > 0});
                chk({nm, "_fvec"}, {6'd0, fvec0}, (errs > 0) ? 8'(first) : 8'd0);
            end
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        chk({nm, "_done_once"}, {7'd0, done0}, 8'd0);
        chk({nm, "_errcnt_hold"}, {5'd0, err0}, 8'(errs));
        @(posedge clk); #1;
        chk({nm, "_idle"}, {7'd0, busy0}, 8'd0);
        chk({nm, "_pulses"}, 8'(done_cnt0 - d0), 8'd1);
    endtask

    initial begin
        int d0;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        op0    = 2'b00;
        op1    = 2'b00;
        tt0    = 4'b1000;
        tt1    = 4'b0111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {7'd0, busy0}, 8'd0);
        chk("rst_done", {7'd0, done0}, 8'd0);
        chk("rst_ab", {6'd0, a0, b0}, 8'd0);
        chk("rst_pass", {7'd0, pass0}, 8'd0);
        chk("rst_err", {5'd0, err0}, 8'd0);
        chk("rst_fev", {7'd0, fev0}, 8'd0);
        chk("rst_fvec", {6'd0, fvec0}, 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run0(2'b00, 4'b1000, 1'b0, "and_and");
        run0(2'b01, 4'b1000, 1'b0, "and_or");
        run0(2'b11, 4'b1111, 1'b0, "one_nand");
        run0(2'b10, 4'b0110, 1'b1, "xor_hold");

        // Reset mid-run discards everything and produces no done pulse.
        tt0    = 4'b1000;
        op0    = 2'b00;
        start0 = 1'b1;
        d0     = done_cnt0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", {7'd0, busy0}, 8'd0);
        chk("mid_rst_done", {7'd0, done0}, 8'd0);
        chk("mid_rst_ab", {6'd0, a0, b0}, 8'd0);
        chk("mid_rst_pass", {7'd0, pass0}, 8'd0);
        chk("mid_rst_err", {5'd0, err0}, 8'd0);
        chk("mid_rst_fev", {7'd0, fev0}, 8'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_nodone", 8'(done_cnt0 - d0), 8'd0);
        chk("mid_rst_still_idle", {7'd0, busy0}, 8'd0);
        run0(2'b00, 4'b1000, 1'b0, "after_rst");

        // rst beats start in the same cycle.
        start0 = 1'b1;
        rst    = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        rst    = 1'b0;
        chk("rst_vs_start", {7'd0, busy0}, 8'd0);

        // Short-settle instance: inverted AND against op AND fails every vector.
        op1    = 2'b00;
        tt1    = 4'b0111;
        start1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            op1    = 2'($urandom);
            chk("s1_done", {7'd0, done1}, {7'd0, c == 9});
            if (c < 9) chk("s1_vec", {6'd0, a1, b1}, 8'((c - 1) / 2));
        end
        chk("s1_err", {5'd0, err1}, 8'd4);
        chk("s1_fvec", {6'd0, fvec1}, 8'd0);
        chk("s1_fev", {7'd0, fev1}, 8'd1);
        chk("s1_pass", {7'd0, pass1}, 8'd0);

        for (int i = 0; i < 8; i++) begin
            run0(2'($urandom), 4'($urandom), 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
